// File: rtl/ex_mul.sv
// ex_mul: multi-cycle 32x32->64 shift-add multiplier for the EX stage.
// Handles MULT/MULTU; MADD/MADDU/MSUB/MSUBU are added when MUL_ACC_EN is defined.
// Stalls the pipeline via stop while iterating and writes HI/LO with a
// one-cycle whilo_o strobe, matching the sequential divider handshake.

`ifndef EXE_RES_MUL
`define AluOpBus      7:0
`define AluSelBus     2:0
`define EXE_RES_MUL   3'b101
`define EXE_MULT_OP   8'b00011000
`define EXE_MULTU_OP  8'b00011001
`define EXE_MADD_OP   8'b10100110
`define EXE_MADDU_OP  8'b10101000
`define EXE_MSUB_OP   8'b10101010
`define EXE_MSUBU_OP  8'b10101011
`endif

module ex_mul (
    input  logic              clk,
    input  logic              rst,
    input  logic [`AluOpBus]  aluop_i,
    input  logic [`AluSelBus] alusel_i,
    input  logic [31:0]       reg1_i,
    input  logic [31:0]       reg2_i,
    input  logic [31:0]       hi_i,
    input  logic [31:0]       lo_i,
    output logic [31:0]       hi_o,
    output logic [31:0]       lo_o,
    output logic              whilo_o,
    output logic              stop
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int unsigned LAST_CNT = 31;

    logic [1:0]  state;
    logic [1:0]  state_nxt;

    logic        op_mul;
    logic        op_signed;
    logic        start;

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [63:0] prod;
    logic [4:0]  cnt;
    logic        neg;

    logic [63:0] addend;
    logic [63:0] prod_sum;
    logic [63:0] res_signed;
    logic [63:0] res_final;

`ifdef MUL_ACC_EN
    localparam logic [1:0] K_MUL = 2'd0;
    localparam logic [1:0] K_ADD = 2'd1;
    localparam logic [1:0] K_SUB = 2'd2;

    logic [1:0]  op_kind;
    logic [1:0]  kind;
    logic [63:0] acc;
`else
    // HI/LO forwarding is only needed by the accumulate ops.
    logic        unused_acc;
    assign unused_acc = &{1'b0, hi_i, lo_i};
`endif

    // Opcode decode: which ops engage the multiplier and which are signed.
    always_comb begin
        op_mul    = 1'b0;
        op_signed = 1'b0;
`ifdef MUL_ACC_EN
        op_kind   = K_MUL;
`endif
        case (aluop_i)
            `EXE_MULT_OP:  begin op_mul = 1'b1; op_signed = 1'b1; end
            `EXE_MULTU_OP: begin op_mul = 1'b1; end
`ifdef MUL_ACC_EN
            `EXE_MADD_OP:  begin op_mul = 1'b1; op_signed = 1'b1; op_kind = K_ADD; end
            `EXE_MADDU_OP: begin op_mul = 1'b1; op_kind = K_ADD; end
            `EXE_MSUB_OP:  begin op_mul = 1'b1; op_signed = 1'b1; op_kind = K_SUB; end
            `EXE_MSUBU_OP: begin op_mul = 1'b1; op_kind = K_SUB; end
`endif
            default: ;
        endcase
    end

    assign start = (state == S_IDLE) && (alusel_i == `EXE_RES_MUL) && op_mul;

    // Operand magnitudes; 0x80000000 maps to itself read as unsigned.
    always_comb begin
        a_neg = op_signed & reg1_i[31];
        b_neg = op_signed & reg2_i[31];
        a_mag = a_neg ? 32'(~reg1_i + 32'd1) : reg1_i;
        b_mag = b_neg ? 32'(~reg2_i + 32'd1) : reg2_i;
    end

    // One shift-add step and the final sign/accumulate stage.
    always_comb begin
        addend     = mplier[0] ? (64'(mcand) << cnt) : 64'd0;
        prod_sum   = 64'(prod + addend);
        res_signed = neg ? 64'(~prod_sum + 64'd1) : prod_sum;
`ifdef MUL_ACC_EN
        case (kind)
            K_ADD:   res_final = 64'(acc + res_signed);
            K_SUB:   res_final = 64'(acc - res_signed);
            default: res_final = res_signed;
        endcase
`else
        res_final = res_signed;
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_BUSY;
            S_BUSY:  if (cnt == 5'(LAST_CNT)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign stop    = start || (state == S_BUSY);
    assign whilo_o = (state == S_DONE);

    // Operand latch, iteration registers and the HI/LO result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= 32'd0;
            mplier <= 32'd0;
            prod   <= 64'd0;
            cnt    <= 5'd0;
            neg    <= 1'b0;
            hi_o   <= 32'd0;
            lo_o   <= 32'd0;
`ifdef MUL_ACC_EN
            kind   <= K_MUL;
            acc    <= 64'd0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand  <= a_mag;
                        mplier <= b_mag;
                        neg    <= op_signed & (reg1_i[31] ^ reg2_i[31]);
                        prod   <= 64'd0;
                        cnt    <= 5'd0;
`ifdef MUL_ACC_EN
                        kind   <= op_kind;
                        acc    <= {hi_i, lo_i};
`endif
                    end
                end
                S_BUSY: begin
                    prod   <= prod_sum;
                    mplier <= {1'b0, mplier[31:1]};
                    cnt    <= 5'(cnt + 5'd1);
                    if (cnt == 5'(LAST_CNT)) begin
                        hi_o <= res_final[63:32];
                        lo_o <= res_final[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
